// File: rtl/t05_cb_sequencer_if.sv
// Handshake bundle between the codebook sequencer, walker, tree memory, header writer and top controller.
// Optional T05_CB_SEQ_PERF_EN adds the stall_cycles counter output.
interface t05_cb_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 71
);
  logic              start;
  logic [ADDR_W-1:0] max_index;
  logic              cb_req;
  logic [ADDR_W-1:0] cb_curr_index;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] h_element;
  logic              h_valid;
  logic              char_found;
  logic              hdr_enable;
  logic              write_finish;
  logic              cb_wait;
  logic              cb_finished;
  logic              busy;
  logic              done;
  logic              error;
  logic [8:0]        code_count;
`ifdef T05_CB_SEQ_PERF_EN
  logic [15:0]       stall_cycles;
`endif

  modport master (
    output start, max_index, cb_req, cb_curr_index, mem_rdata, mem_rvalid,
           char_found, write_finish, cb_finished,
    input  mem_re, mem_addr, h_element, h_valid, hdr_enable, cb_wait,
           busy, done, error, code_count
`ifdef T05_CB_SEQ_PERF_EN
           , stall_cycles
`endif
  );

  modport slave (
    input  start, max_index, cb_req, cb_curr_index, mem_rdata, mem_rvalid,
           char_found, write_finish, cb_finished,
    output mem_re, mem_addr, h_element, h_valid, hdr_enable, cb_wait,
           busy, done, error, code_count
`ifdef T05_CB_SEQ_PERF_EN
           , stall_cycles
`endif
  );
endinterface

// File: rtl/t05_cb_sequencer.sv
// Codebook synthesis sequencer: owns the tree memory port, stalls the walker during header writes.
// Optional T05_CB_SEQ_PERF_EN counts walker stall cycles per run.
module t05_cb_sequencer #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_CODES = 256
) (
  input logic               clk,
  input logic               rst,
  t05_cb_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, DELIVER, WRITE, FINISH, ERR} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_inc;
  logic          tmo;

  // Timeout fires on the cycle the counter would reach TIMEOUT, so it never wraps.
  assign tcnt_inc = tcnt + TW'(1);
  assign tmo      = (tcnt_inc == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tcnt            <= '0;
      bus.mem_re      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.h_element   <= '0;
      bus.h_valid     <= 1'b0;
      bus.hdr_enable  <= 1'b0;
      bus.cb_wait     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.code_count  <= '0;
`ifdef T05_CB_SEQ_PERF_EN
      bus.stall_cycles <= '0;
`endif
    end else begin
      bus.mem_re  <= 1'b0;
      bus.h_valid <= 1'b0;
      bus.done    <= 1'b0;
`ifdef T05_CB_SEQ_PERF_EN
      if (state == IDLE && bus.start)
        bus.stall_cycles <= '0;
      else if (bus.cb_wait && bus.stall_cycles != 16'hFFFF)
        bus.stall_cycles <= bus.stall_cycles + 16'd1;
`endif
      case (state)
        IDLE: if (bus.start) begin
          bus.code_count <= '0;
          bus.error      <= 1'b0;
          bus.busy       <= 1'b1;
          bus.cb_wait    <= 1'b1;
          bus.mem_re     <= 1'b1;
          bus.mem_addr   <= bus.max_index;
          tcnt           <= '0;
          state          <= FETCH;
        end
        FETCH: state <= WAIT_MEM;
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            bus.h_element <= bus.mem_rdata;
            bus.h_valid   <= 1'b1;
            bus.cb_wait   <= 1'b0;
            tcnt          <= '0;
            state         <= DELIVER;
          end else if (tmo) begin
            bus.error <= 1'b1;
            state     <= ERR;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        DELIVER: begin
          tcnt <= '0;
          if (bus.cb_finished) begin
            bus.done <= 1'b1;
            state    <= FINISH;
          end else if (bus.char_found) begin
            // A character beyond MAX_CODES is a malformed tree; abort the run.
            if (bus.code_count == 9'(MAX_CODES)) begin
              bus.error   <= 1'b1;
              bus.cb_wait <= 1'b1;
              state       <= ERR;
            end else begin
              bus.code_count <= bus.code_count + 9'd1;
              bus.hdr_enable <= 1'b1;
              bus.cb_wait    <= 1'b1;
              state          <= WRITE;
            end
          end else if (bus.cb_req) begin
            bus.mem_re   <= 1'b1;
            bus.mem_addr <= bus.cb_curr_index;
            bus.cb_wait  <= 1'b1;
            state        <= FETCH;
          end
        end
        WRITE: begin
          if (bus.write_finish) begin
            bus.hdr_enable <= 1'b0;
            bus.cb_wait    <= 1'b0;
            tcnt           <= '0;
            state          <= DELIVER;
          end else if (tmo) begin
            bus.hdr_enable <= 1'b0;
            bus.error      <= 1'b1;
            state          <= ERR;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          bus.busy    <= 1'b0;
          bus.cb_wait <= 1'b0;
          tcnt        <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
